// File: rtl/sd_nios2_attempt_sd_status_ctrl.sv
// SD socket status controller: synchronises and debounces the write-protect and
// card-detect pins, latches every debounced change and raises a maskable IRQ.
module sd_nios2_attempt_sd_status_ctrl #(
   parameter int CNT_W       = 16,
   parameter int DEB_DEFAULT = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        wp_n_in,
   input  logic        cd_n_in,
   output logic        wp_n_db,
   output logic        cd_n_db,
   output logic        irq
);

   typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

   // Channel index 0 is write-protect, 1 is card-detect throughout.
   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       db_q, db_d;
   state_t           st_q [2];
   state_t           st_d [2];
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       mask_q, mask_d;
   logic [1:0]       ecap_q, ecap_d;
   logic [CNT_W-1:0] deb_q, deb_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       set_s, clr_s;
   logic [CNT_W-1:0] thr_s;
   logic             wr_s;

   assign wr_s  = chipselect & ~write_n;
   assign thr_s = (deb_q == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : deb_q;

   // Debounce FSMs, register writes, edge capture and read mux.
   always_comb begin
      db_d   = db_q;
      mask_d = mask_q;
      deb_d  = deb_q;
      set_s  = 2'b00;
      clr_s  = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
         st_d[ch]  = st_q[ch];
         cnt_d[ch] = cnt_q[ch];
         case (st_q[ch])
            IDLE: begin
               if (sync2_q[ch] != db_q[ch]) begin
                  st_d[ch]  = COUNT;
                  cnt_d[ch] = {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  st_d[ch]  = IDLE;
                  cnt_d[ch] = {CNT_W{1'b0}};
               end
            end
            COUNT: begin
               if (sync2_q[ch] == db_q[ch]) begin
                  st_d[ch]  = IDLE;
                  cnt_d[ch] = {CNT_W{1'b0}};
               end else if (cnt_q[ch] >= thr_s) begin
                  db_d[ch]  = sync2_q[ch];
                  set_s[ch] = 1'b1;
                  st_d[ch]  = IDLE;
                  cnt_d[ch] = {CNT_W{1'b0}};
               end else if (&cnt_q[ch]) begin
                  cnt_d[ch] = cnt_q[ch];
               end else begin
                  cnt_d[ch] = cnt_q[ch] + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               st_d[ch]  = IDLE;
               cnt_d[ch] = {CNT_W{1'b0}};
            end
         endcase
      end
      if (wr_s) begin
         case (address)
            2'd1:    mask_d = writedata[1:0];
            2'd2:    clr_s  = writedata[1:0];
            2'd3:    deb_d  = writedata[CNT_W-1:0];
            default: mask_d = mask_q;
         endcase
      end else begin
         mask_d = mask_q;
      end
      // A capture in the same cycle as its W1C clear must survive.
      ecap_d = (ecap_q & ~clr_s) | set_s;
      case (address)
         2'd0:    rdata_d = {30'd0, db_q};
         2'd1:    rdata_d = {30'd0, mask_q};
         2'd2:    rdata_d = {30'd0, ecap_q};
         2'd3:    rdata_d = {{(32-CNT_W){1'b0}}, deb_q};
         default: rdata_d = 32'd0;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         db_q    <= 2'b11;
         mask_q  <= 2'b00;
         ecap_q  <= 2'b00;
         deb_q   <= CNT_W'(DEB_DEFAULT);
         rdata_q <= 32'd0;
         for (int ch = 0; ch < 2; ch++) begin
            st_q[ch]  <= IDLE;
            cnt_q[ch] <= {CNT_W{1'b0}};
         end
      end else begin
         sync1_q <= {cd_n_in, wp_n_in};
         sync2_q <= sync1_q;
         db_q    <= db_d;
         mask_q  <= mask_d;
         ecap_q  <= ecap_d;
         deb_q   <= deb_d;
         rdata_q <= rdata_d;
         for (int ch = 0; ch < 2; ch++) begin
            st_q[ch]  <= st_d[ch];
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   assign readdata = rdata_q;
   assign wp_n_db  = db_q[0];
   assign cd_n_db  = db_q[1];
   assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_sd_nios2_attempt_sd_status_ctrl.sv
// Directed bench for the SD status controller: register map, debounce timing,
// glitch rejection, IRQ masking, capture/clear collision and mid-count reset.
module tb_sd_nios2_attempt_sd_status_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        wp_n_in = 1'b1;
   logic        cd_n_in = 1'b1;
   logic        wp_n_db, cd_n_db, irq;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   sd_nios2_attempt_sd_status_ctrl #(.CNT_W(16), .DEB_DEFAULT(50000)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .wp_n_in(wp_n_in), .cd_n_in(cd_n_in),
      .wp_n_db(wp_n_db), .cd_n_db(cd_n_db), .irq(irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      cyc(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      cyc(1);
      d = readdata;
   endtask

   logic [31:0] r;

   initial begin
      #12;
      check("reset_readdata", readdata, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      cyc(1);

      // 1: reset register values
      rd(2'd0, r); check("rst_data", r, 32'h3);
      rd(2'd1, r); check("rst_mask", r, 32'h0);
      rd(2'd2, r); check("rst_ecap", r, 32'h0);
      rd(2'd3, r); check("rst_deb", r, 32'd50000);
      check("rst_irq", {31'd0, irq}, 32'd0);

      // 2: wp falls exactly 7 cycles after the pin edge
      wr(2'd3, 32'd4);
      wp_n_in = 1'b0;
      cyc(6); check("wp_db_before", {31'd0, wp_n_db}, 32'd1);
      cyc(1); check("wp_db_after", {31'd0, wp_n_db}, 32'd0);
      rd(2'd2, r); check("wp_ecap", r, 32'h1);
      rd(2'd0, r); check("wp_data", r, 32'h2);
      wr(2'd2, 32'h1);
      rd(2'd2, r); check("ecap_cleared", r, 32'h0);

      // 3: 3-cycle cd glitch rejected
      cd_n_in = 1'b0; cyc(3); cd_n_in = 1'b1;
      cyc(8); check("glitch_cd_db", {31'd0, cd_n_db}, 32'd1);
      rd(2'd2, r); check("glitch_ecap", r, 32'h0);

      // 4: masked cd capture drives irq; W1C drops it the next cycle
      wr(2'd1, 32'h2);
      cd_n_in = 1'b0;
      cyc(7); check("cd_db", {31'd0, cd_n_db}, 32'd0);
      check("cd_irq", {31'd0, irq}, 32'd1);
      address = 2'd2; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
      #3; check("irq_before_clr", {31'd0, irq}, 32'd1);
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      check("irq_after_clr", {31'd0, irq}, 32'd0);

      // 5: W1C of bit0 on the wp commit cycle - set wins
      wp_n_in = 1'b1;
      cyc(6);
      wr(2'd2, 32'h1);
      check("coll_wp_db", {31'd0, wp_n_db}, 32'd1);
      rd(2'd2, r); check("coll_ecap", r, 32'h1);
      check("coll_irq_masked", {31'd0, irq}, 32'd0);
      wr(2'd1, 32'h3);
      check("coll_irq_unmasked", {31'd0, irq}, 32'd1);
      wr(2'd2, 32'h3);
      check("irq_all_clr", {31'd0, irq}, 32'd0);

      // 6: DEBOUNCE=0 acts as threshold 1
      wr(2'd3, 32'd0);
      rd(2'd3, r); check("deb_zero", r, 32'h0);
      wp_n_in = 1'b0; cyc(2); wp_n_in = 1'b1;
      cyc(2); check("thr1_wp_low", {31'd0, wp_n_db}, 32'd0);
      cyc(2); check("thr1_wp_high", {31'd0, wp_n_db}, 32'd1);
      rd(2'd2, r); check("thr1_ecap", r, 32'h1);

      // reset in the middle of a count
      wr(2'd3, 32'd10);
      wp_n_in = 1'b0;
      cyc(5); check("midcnt_wp_db", {31'd0, wp_n_db}, 32'd1);
      #2 reset_n = 1'b0;
      #2 check("rst_wp_db", {31'd0, wp_n_db}, 32'd1);
      check("rst_cd_db", {31'd0, cd_n_db}, 32'd1);
      check("rst_irq2", {31'd0, irq}, 32'd0);
      check("rst_rdata2", readdata, 32'd0);
      #2 reset_n = 1'b1;
      cyc(1);
      rd(2'd3, r); check("rst_deb2", r, 32'd50000);
      cyc(20); check("post_rst_wp_db", {31'd0, wp_n_db}, 32'd1);
      rd(2'd2, r); check("post_rst_ecap", r, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
